demap_frame_ctrl: RTL and testbench
===================================

Name: demap_frame_ctrl

Overview:
Frame-level sequencer in front of the multi-mode APSK exhaustive demapper (CHIP). It accepts one frame request at a time: mode plus N0/2 config. It then drives the demapper's Mode and N0/2 inputs for the whole frame and gates the symbol stream into the demapper with a valid/ready handshake. After the last symbol it drains the demapper pipeline, then forces Mode back to 0 before the next frame. This guarantees a clean idle gap between mode switches.

Parameters:
CNT_W, 15, width of symbol/drain counters (must hold 32400)
PIPE_LAT, 9, demapper input-to-LLR latency in clocks (drain length)
NSYM_QPSK, 32400, symbols per 64800-bit frame, mode 1
NSYM_8PSK, 21600, mode 2
NSYM_16APSK, 16200, mode 3
NSYM_32APSK, 12960, mode 4
NSYM_64APSK, 10800, mode 5

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
frame_req  in  1  request a new frame (level, sampled only in IDLE)
frame_mode  in  3  requested mode, 1..5 valid
frame_n0_2  in  19  signed N0/2 value for the frame
frame_ack  out  1  one-cycle pulse: request accepted
frame_err  out  1  one-cycle pulse: request rejected (mode 0/6/7)
abort  in  1  abandon the current frame
s_valid  in  1  upstream symbol (4x18-bit h/u sample) available
s_ready  out  1  controller accepts symbol this cycle
dm_in_valid  out  1  symbol presented to demapper this cycle
dm_mode  out  3  Mode to demapper (0 = idle)
dm_n0_2  out  19  N0/2 to demapper
busy  out  1  high in any state but IDLE
frame_done  out  1  one-cycle pulse: frame fully drained
frame_aborted  out  1  one-cycle pulse: frame abandoned via abort

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; sym_cnt, drain_cnt, dm_mode, dm_n0_2 = 0. frame_ack, frame_err, frame_done and frame_aborted = 0. Reset overrides abort and frame_req in the same cycle.
- States: IDLE, CONFIG, STREAM, DRAIN, DONE.
- IDLE:
  - dm_mode=0, s_ready=0.
  - frame_req=1 with frame_mode in 1..5 -> CONFIG. At the same edge, dm_mode<=frame_mode, dm_n0_2<=frame_n0_2, nsym<=table(frame_mode), sym_cnt<=0.
  - frame_req=1 with mode 0/6/7 -> stay IDLE; frame_err=1 for the next cycle.
- CONFIG: exactly one cycle; frame_ack=1 -> STREAM. The demapper sees the new Mode/N0 one cycle before the first symbol.
- STREAM:
  - s_ready=1 (combinational from state).
  - dm_in_valid = s_valid & s_ready. Each accepted beat does sym_cnt+1.
  - A beat accepted while sym_cnt==nsym-1 -> DRAIN with drain_cnt<=0. s_ready is 0 in the following cycle.
  - s_valid gaps are allowed; the counter holds.
- DRAIN: s_ready=0; drain_cnt increments each cycle; at drain_cnt==PIPE_LAT-1 -> DONE. dm_mode and dm_n0_2 are held.
- DONE: one cycle; frame_done=1 -> IDLE. dm_mode<=0 at that edge. frame_req is ignored in DONE, so there is at least one IDLE cycle with dm_mode=0 between frames.
- abort=1 in CONFIG/STREAM/DRAIN/DONE:
  - next state IDLE, dm_mode<=0, counters<=0.
  - frame_aborted=1 next cycle; frame_done not pulsed.
  - A beat coincident with abort is still accepted (dm_in_valid follows s_valid&s_ready), but it is not counted.
  - abort in IDLE has no effect.
- dm_n0_2 is held from CONFIG until the next accepted request; it is not cleared in IDLE.
- frame_mode/frame_n0_2 are sampled only at the accepting edge; later changes have no effect.
- All flag outputs are registered except s_ready and dm_in_valid.

Test Plan:
- Reset: rst=1 for 3 cycles with frame_req=1, mode=1 -> busy=0, dm_mode=0, no ack/err. After release, ack 2 cycles after the req edge.
- QPSK frame, N0_2=19'b0000001001001001000, s_valid=1 continuous:
  - exactly 32400 dm_in_valid cycles, then s_ready=0.
  - frame_done 10 cycles after the last beat (9 drain + DONE); dm_mode=0 the cycle after.
- Back-to-back modes 2,3,4,5, each frame_req held high:
  - 21600/16200/12960/10800 beats respectively.
  - dm_mode shows 0 for at least 1 cycle between frames; dm_n0_2 updates only at each CONFIG.
- 64-APSK with s_valid toggling 1-0 -> 10800 accepted beats over ~21600 cycles; sym_cnt holds during gaps.
- frame_mode=6 in IDLE -> frame_err pulse, busy stays 0. frame_mode=0 gives the same.
- abort at beat 500 of a 16-APSK frame -> next cycle IDLE, frame_aborted=1, no frame_done. A following mode-1 request completes normally with 32400 beats.

Source files
------------

// File: rtl/demap_frame_ctrl.sv
// demap_frame_ctrl
// Frame-level sequencer for the multi-mode APSK exhaustive demapper.
// Accepts one frame request at a time and latches its Mode and N0/2.
// Gates the symbol stream into the demapper for exactly one frame's
// worth of symbols, then drains the demapper pipeline. Mode is forced
// back to 0 before the next frame so that every mode switch is separated
// by at least one idle cycle.
//
// Symbol handshake (valid/ready):
//   A beat transfers on a rising edge where s_valid && s_ready are both 1.
//   s_ready depends only on the controller state and never on s_valid.
//   Upstream must hold s_valid (and its data) until the beat transfers.
//   dm_in_valid marks the transferring cycle towards the demapper, so the
//   demapper samples the symbol on the same edge the handshake completes.
module demap_frame_ctrl #(
  parameter int CNT_W       = 15,
  parameter int PIPE_LAT    = 9,
  parameter int NSYM_QPSK   = 32400,
  parameter int NSYM_8PSK   = 21600,
  parameter int NSYM_16APSK = 16200,
  parameter int NSYM_32APSK = 12960,
  parameter int NSYM_64APSK = 10800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_req,
  input  logic [2:0]  frame_mode,
  input  logic [18:0] frame_n0_2,
  output logic        frame_ack,
  output logic        frame_err,
  input  logic        abort,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        dm_in_valid,
  output logic [2:0]  dm_mode,
  output logic [18:0] dm_n0_2,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_aborted,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CONFIG = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] sym_cnt_q;
  logic [CNT_W-1:0] sym_cnt_d;
  logic [CNT_W-1:0] drain_cnt_q;
  logic [CNT_W-1:0] drain_cnt_d;
  logic [CNT_W-1:0] nsym_q;
  logic [2:0]       dm_mode_q;
  logic [18:0]      dm_n0_2_q;
  logic             frame_ack_q;
  logic             frame_err_q;
  logic             frame_done_q;
  logic             frame_aborted_q;
  logic             busy_q;

  logic             mode_ok;
  logic             beat;
  logic             last_beat;
  logic             drain_last;
  logic [CNT_W-1:0] nsym_lookup;

  // Symbols per 64800-bit frame for each valid mode; 0 for illegal modes.
  function automatic logic [CNT_W-1:0] nsym_of(input logic [2:0] m);
    case (m)
      3'd1:    return CNT_W'(NSYM_QPSK);
      3'd2:    return CNT_W'(NSYM_8PSK);
      3'd3:    return CNT_W'(NSYM_16APSK);
      3'd4:    return CNT_W'(NSYM_32APSK);
      3'd5:    return CNT_W'(NSYM_64APSK);
      default: return '0;
    endcase
  endfunction

  // Request decode, handshake and counter next-values.
  always_comb begin
    mode_ok     = (frame_mode != 3'd0) && (frame_mode <= 3'd5);
    nsym_lookup = nsym_of(frame_mode);
    beat        = s_valid && (state_q == S_STREAM);
    last_beat   = (sym_cnt_q == (nsym_q - 1'b1));
    drain_last  = (drain_cnt_q == CNT_W'(PIPE_LAT - 1));
    sym_cnt_d   = sym_cnt_q + 1'b1;
    drain_cnt_d = drain_cnt_q + 1'b1;
  end

  // Frame FSM with all flag and demapper-control outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      sym_cnt_q       <= '0;
      drain_cnt_q     <= '0;
      nsym_q          <= '0;
      dm_mode_q       <= 3'd0;
      dm_n0_2_q       <= 19'd0;
      frame_ack_q     <= 1'b0;
      frame_err_q     <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_aborted_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      // Pulses default low; each is raised for exactly one cycle below.
      frame_ack_q     <= 1'b0;
      frame_err_q     <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_aborted_q <= 1'b0;

      if (abort && (state_q != S_IDLE)) begin
        // Abandon the frame; a beat coincident with abort is not counted.
        // dm_n0_2 is deliberately kept until the next accepted request.
        state_q         <= S_IDLE;
        dm_mode_q       <= 3'd0;
        sym_cnt_q       <= '0;
        drain_cnt_q     <= '0;
        frame_aborted_q <= 1'b1;
        busy_q          <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (frame_req) begin
              if (mode_ok) begin
                state_q     <= S_CONFIG;
                dm_mode_q   <= frame_mode;
                dm_n0_2_q   <= frame_n0_2;
                nsym_q      <= nsym_lookup;
                sym_cnt_q   <= '0;
                frame_ack_q <= 1'b1;
                busy_q      <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
            end
          end

          // One settle cycle: the demapper sees the new Mode/N0 before
          // the first symbol arrives.
          S_CONFIG: begin
            state_q <= S_STREAM;
          end

          S_STREAM: begin
            if (beat) begin
              sym_cnt_q <= sym_cnt_d;
              if (last_beat) begin
                state_q     <= S_DRAIN;
                drain_cnt_q <= '0;
              end
            end
          end

          // Let the last symbol propagate through the demapper pipeline.
          S_DRAIN: begin
            drain_cnt_q <= drain_cnt_d;
            if (drain_last) begin
              state_q      <= S_DONE;
              frame_done_q <= 1'b1;
            end
          end

          // frame_req is not looked at here, guaranteeing an IDLE cycle
          // with Mode 0 before any following frame.
          S_DONE: begin
            state_q   <= S_IDLE;
            dm_mode_q <= 3'd0;
            busy_q    <= 1'b0;
          end

          default: begin
            state_q   <= S_IDLE;
            dm_mode_q <= 3'd0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output mapping; only s_ready and dm_in_valid are combinational.
  always_comb begin
    s_ready       = (state_q == S_STREAM);
    dm_in_valid   = beat;
    dm_mode       = dm_mode_q;
    dm_n0_2       = dm_n0_2_q;
    frame_ack     = frame_ack_q;
    frame_err     = frame_err_q;
    frame_done    = frame_done_q;
    frame_aborted = frame_aborted_q;
    busy          = busy_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_demap_frame_ctrl.sv
// tb_demap_frame_ctrl
// Directed bench for the demapper frame sequencer. Frame lengths are
// shortened through the NSYM_* parameters so every mode runs full frames
// quickly; drain latency keeps its real value of 9.
module tb_demap_frame_ctrl;

  localparam int NQ   = 48;
  localparam int N8   = 32;
  localparam int N16  = 24;
  localparam int N32  = 20;
  localparam int N64  = 16;

  localparam logic [18:0] N0_Q = 19'b0000001001001001000;
  localparam logic [18:0] N0_A = 19'h7FFFF;
  localparam logic [18:0] N0_B = 19'h40000;
  localparam logic [18:0] N0_C = 19'h12345;
  localparam logic [18:0] N0_D = 19'h0ABCD;
  localparam logic [18:0] N0_F = 19'h00001;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst;
  logic        frame_req;
  logic [2:0]  frame_mode;
  logic [18:0] frame_n0_2;
  logic        frame_ack;
  logic        frame_err;
  logic        abort;
  logic        s_valid;
  logic        s_ready;
  logic        dm_in_valid;
  logic [2:0]  dm_mode;
  logic [18:0] dm_n0_2;
  logic        busy;
  logic        frame_done;
  logic        frame_aborted;
  logic [2:0]  dbg_state;

  int total;
  int bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  demap_frame_ctrl #(
    .CNT_W       (15),
    .PIPE_LAT    (9),
    .NSYM_QPSK   (NQ),
    .NSYM_8PSK   (N8),
    .NSYM_16APSK (N16),
    .NSYM_32APSK (N32),
    .NSYM_64APSK (N64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_req     (frame_req),
    .frame_mode    (frame_mode),
    .frame_n0_2    (frame_n0_2),
    .frame_ack     (frame_ack),
    .frame_err     (frame_err),
    .abort         (abort),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .dm_in_valid   (dm_in_valid),
    .dm_mode       (dm_mode),
    .dm_n0_2       (dm_n0_2),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_aborted (frame_aborted),
    .dbg_state     (dbg_state)
  );

  // ---------------- helpers ----------------
  // Advance to the falling edge following the next rising edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // From IDLE: request a frame, check CONFIG, then scramble the request
  // inputs and check they do not leak into the latched configuration.
  task automatic start_frame(input logic [2:0] m, input logic [18:0] n0);
    frame_req  = 1'b1;
    frame_mode = m;
    frame_n0_2 = n0;
    tick();
    check("cfg_ack",   {31'd0, frame_ack}, 32'd1);
    check("cfg_busy",  {31'd0, busy}, 32'd1);
    check("cfg_mode",  {29'd0, dm_mode}, {29'd0, m});
    check("cfg_n0",    {13'd0, dm_n0_2}, {13'd0, n0});
    check("cfg_ready", {31'd0, s_ready}, 32'd0);
    frame_mode = (m == 3'd5) ? 3'd1 : m + 3'd1;
    frame_n0_2 = ~n0;
    tick();
    check("str_ready", {31'd0, s_ready}, 32'd1);
    check("str_ack",   {31'd0, frame_ack}, 32'd0);
    check("str_mode",  {29'd0, dm_mode}, {29'd0, m});
    check("str_n0",    {13'd0, dm_n0_2}, {13'd0, n0});
  endtask

  // In STREAM: feed symbols (continuous or 1-0 toggling) until exp beats
  // have been seen, then confirm the controller stops accepting.
  task automatic stream_frame(input int exp, input bit toggle);
    int beats;
    int cyc;
    bit ready_lost;
    beats = 0;
    cyc = 0;
    ready_lost = 1'b0;
    while ((beats < exp) && (cyc < 3 * exp + 20)) begin
      s_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      if (!s_ready) ready_lost = 1'b1;
      if (dm_in_valid) beats++;
      tick();
      cyc++;
    end
    check("beats",      beats, exp);
    check("beat_cyc",   cyc, toggle ? (2 * exp - 1) : exp);
    check("ready_held", {31'd0, ready_lost}, 32'd0);
    s_valid = 1'b1;
    #1;
    check("post_ready", {31'd0, s_ready}, 32'd0);
    check("post_dmv",   {31'd0, dm_in_valid}, 32'd0);
    check("post_busy",  {31'd0, busy}, 32'd1);
    s_valid = 1'b0;
  endtask

  // In the first DRAIN cycle: 8 more drain cycles, then DONE, then IDLE.
  task automatic finish_frame(input logic [2:0] m, input logic [18:0] n0);
    bit early;
    early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (frame_done || !busy || s_ready || (dm_mode != m)) early = 1'b1;
    end
    check("drain_quiet", {31'd0, early}, 32'd0);
    tick();
    check("done_pulse", {31'd0, frame_done}, 32'd1);
    check("done_mode",  {29'd0, dm_mode}, {29'd0, m});
    tick();
    check("idle_done",  {31'd0, frame_done}, 32'd0);
    check("idle_mode",  {29'd0, dm_mode}, 32'd0);
    check("idle_busy",  {31'd0, busy}, 32'd0);
    check("idle_ack",   {31'd0, frame_ack}, 32'd0);
    check("idle_n0",    {13'd0, dm_n0_2}, {13'd0, n0});
  endtask

  task automatic err_test(input logic [2:0] m, input logic [18:0] held_n0);
    frame_req  = 1'b1;
    frame_mode = m;
    frame_n0_2 = 19'h55555;
    tick();
    check("err_pulse", {31'd0, frame_err}, 32'd1);
    check("err_busy",  {31'd0, busy}, 32'd0);
    check("err_ack",   {31'd0, frame_ack}, 32'd0);
    check("err_n0",    {13'd0, dm_n0_2}, {13'd0, held_n0});
    frame_req = 1'b0;
    tick();
    check("err_clear", {31'd0, frame_err}, 32'd0);
    check("err_idle",  {31'd0, busy}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    total = 0;
    bad   = 0;
    rst        = 1'b1;
    frame_req  = 1'b1;
    frame_mode = 3'd1;
    frame_n0_2 = N0_Q;
    abort      = 1'b0;
    s_valid    = 1'b0;

    // Reset held with a pending request: nothing may start.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_mode", {29'd0, dm_mode}, 32'd0);
      check("rst_ack",  {31'd0, frame_ack}, 32'd0);
      check("rst_err",  {31'd0, frame_err}, 32'd0);
      check("rst_n0",   {13'd0, dm_n0_2}, 32'd0);
    end
    rst = 1'b0;

    // QPSK frame, continuous valid.
    start_frame(3'd1, N0_Q);
    stream_frame(NQ, 1'b0);
    frame_req = 1'b0;
    finish_frame(3'd1, N0_Q);

    // Back-to-back modes 2..5 with the request held high throughout.
    start_frame(3'd2, N0_A);
    stream_frame(N8, 1'b0);
    frame_req = 1'b1; frame_mode = 3'd3; frame_n0_2 = N0_B;
    finish_frame(3'd2, N0_A);
    start_frame(3'd3, N0_B);
    stream_frame(N16, 1'b0);
    frame_req = 1'b1; frame_mode = 3'd4; frame_n0_2 = N0_C;
    finish_frame(3'd3, N0_B);
    start_frame(3'd4, N0_C);
    stream_frame(N32, 1'b0);
    frame_req = 1'b1; frame_mode = 3'd5; frame_n0_2 = N0_D;
    finish_frame(3'd4, N0_C);
    start_frame(3'd5, N0_D);
    stream_frame(N64, 1'b0);
    frame_req = 1'b0;
    finish_frame(3'd5, N0_D);

    // 64-APSK with toggling valid: counter must hold through gaps.
    start_frame(3'd5, N0_C);
    stream_frame(N64, 1'b1);
    frame_req = 1'b0;
    finish_frame(3'd5, N0_C);

    // Illegal modes are rejected and leave N0/2 untouched.
    err_test(3'd6, N0_C);
    err_test(3'd0, N0_C);
    err_test(3'd7, N0_C);

    // Abort while idle does nothing.
    abort = 1'b1;
    tick();
    check("idle_abort_flag", {31'd0, frame_aborted}, 32'd0);
    check("idle_abort_busy", {31'd0, busy}, 32'd0);
    abort = 1'b0;

    // Abort part-way through a 16-APSK frame.
    start_frame(3'd3, N0_B);
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      tick();
    end
    abort = 1'b1;
    #1;
    check("abort_beat", {31'd0, dm_in_valid}, 32'd1);
    tick();
    frame_req = 1'b0;
    abort     = 1'b0;
    s_valid   = 1'b0;
    check("abort_flag",  {31'd0, frame_aborted}, 32'd1);
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_mode",  {29'd0, dm_mode}, 32'd0);
    check("abort_ready", {31'd0, s_ready}, 32'd0);
    check("abort_done",  {31'd0, frame_done}, 32'd0);
    tick();
    check("abort_clear", {31'd0, frame_aborted}, 32'd0);
    check("abort_nodone", {31'd0, frame_done}, 32'd0);
    check("abort_n0",    {13'd0, dm_n0_2}, {13'd0, N0_B});

    // A full QPSK frame after the abort.
    start_frame(3'd1, N0_F);
    stream_frame(NQ, 1'b0);
    frame_req = 1'b0;
    finish_frame(3'd1, N0_F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
